coin_acceptor: RTL and testbench

Upstream payment stage for the washing machine controller. It accepts 5- and 10-unit coin pulses and accumulates credit. Once credit covers the price of the selected mode, it issues a one-cycle `o_coin` pulse to the machine and dispenses any change. It refunds credit on cancel, on inactivity timeout, or when the machine raises its coin-return output.

---
 rtl/coin_acceptor.sv | 185 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor: accumulates 5/10-unit coin credit, pays the washing machine once the
// selected mode's price is covered, and dispenses change or refunds one coin per cycle.
module coin_acceptor #(
    parameter int PRICE_1  = 10,
    parameter int PRICE_2  = 20,
    parameter int PRICE_3  = 30,
    parameter int CREDIT_W = 7,
    parameter int TIMEOUT  = 200
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_coin_5,
    input  logic                i_coin_10,
    input  logic                i_mode_1,
    input  logic                i_mode_2,
    input  logic                i_mode_3,
    input  logic                i_cancel,
    input  logic                i_coinreturn,
    input  logic                i_done,
    output logic                o_coin,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_refund_10,
    output logic                o_refund_5,
    output logic                o_reject,
    output logic                o_busy,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_PAID    = 3'd4,
        ST_REFUND  = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CREDIT_W-1:0] P1        = CREDIT_W'(PRICE_1);
    localparam logic [CREDIT_W-1:0] P2        = CREDIT_W'(PRICE_2);
    localparam logic [CREDIT_W-1:0] P3        = CREDIT_W'(PRICE_3);
    localparam logic [CREDIT_W-1:0] FIVE      = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN       = CREDIT_W'(10);
    localparam logic [CREDIT_W:0]   V5        = (CREDIT_W + 1)'(5);
    localparam logic [CREDIT_W:0]   V10       = (CREDIT_W + 1)'(10);
    localparam logic [CREDIT_W:0]   V15       = (CREDIT_W + 1)'(15);
    localparam logic [CREDIT_W:0]   CREDIT_MX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CNT_W-1:0]    TO_CNT    = CNT_W'(TIMEOUT);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   price_q, price_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  reject_q, reject_d;

    logic                  coin_any;
    logic                  coin_fits;
    logic                  mode_sel;
    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     coin_sum;
    logic [CREDIT_W-1:0]   price_act;
    logic [CREDIT_W-1:0]   disp_val;
    logic [CREDIT_W-1:0]   disp_rem;

    always_comb begin
        coin_val = '0;
        case ({i_coin_10, i_coin_5})
            2'b01:   coin_val = V5;
            2'b10:   coin_val = V10;
            2'b11:   coin_val = V15;
            default: coin_val = '0;
        endcase
        coin_any  = i_coin_5 | i_coin_10;
        coin_sum  = {1'b0, credit_q} + coin_val;
        coin_fits = (coin_sum <= CREDIT_MX);

        mode_sel  = i_mode_1 | i_mode_2 | i_mode_3;
        price_act = '0;
        if (i_mode_1)      price_act = P1;
        else if (i_mode_2) price_act = P2;
        else if (i_mode_3) price_act = P3;

        // Change and refund share one dispenser: largest coin that still fits.
        disp_val = '0;
        if (credit_q >= TEN)    disp_val = TEN;
        else if (credit_q != 0) disp_val = FIVE;
        disp_rem = credit_q - disp_val;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        cnt_d    = cnt_q;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        cnt_d    = '0;
                        state_d  = ST_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (i_cancel && credit_q != 0) begin
                    reject_d = coin_any;
                    state_d  = ST_REFUND;
                end else if (cnt_q == TO_CNT) begin
                    reject_d = coin_any;
                    state_d  = ST_REFUND;
                end else if (mode_sel && credit_q >= price_act) begin
                    // Price captured at the decision so a mode change during VEND cannot underflow credit.
                    reject_d = coin_any;
                    price_d  = price_act;
                    state_d  = ST_VEND;
                end else if (coin_any && coin_fits) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    cnt_d    = '0;
                end else begin
                    reject_d = coin_any;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_VEND: begin
                reject_d = coin_any;
                credit_d = credit_q - price_q;
                state_d  = (credit_q != price_q) ? ST_CHANGE : ST_PAID;
            end
            ST_CHANGE: begin
                reject_d = coin_any;
                credit_d = disp_rem;
                if (disp_rem == 0) state_d = ST_PAID;
            end
            ST_PAID: begin
                reject_d = coin_any;
                if (i_coinreturn) begin
                    credit_d = price_q;
                    state_d  = ST_REFUND;
                end else if (i_done) begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REFUND: begin
                reject_d = coin_any;
                credit_d = disp_rem;
                if (disp_rem == 0) state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            cnt_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            cnt_q    <= cnt_d;
            reject_q <= reject_d;
        end
    end

    assign o_coin      = (state_q == ST_VEND);
    assign o_credit    = credit_q;
    assign o_refund_10 = (state_q == ST_CHANGE || state_q == ST_REFUND) && (credit_q >= TEN);
    assign o_refund_5  = (state_q == ST_CHANGE || state_q == ST_REFUND) && (credit_q != 0)
                         && (credit_q < TEN);
    assign o_reject    = reject_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_state     = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: payment, change, cancel, timeout, coin return,
// saturation and asynchronous reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_coin_acceptor;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_CHANGE  = 3'd3;
  localparam logic [2:0] S_PAID    = 3'd4;
  localparam logic [2:0] S_REFUND  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_5, coin_10, mode_1, mode_2, mode_3, cancel, coinreturn, done;
  logic       o_coin, o_refund_10, o_refund_5, o_reject, o_busy;
  logic [6:0] o_credit;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;

  coin_acceptor dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_coin_5     (coin_5),
    .i_coin_10    (coin_10),
    .i_mode_1     (mode_1),
    .i_mode_2     (mode_2),
    .i_mode_3     (mode_3),
    .i_cancel     (cancel),
    .i_coinreturn (coinreturn),
    .i_done       (done),
    .o_coin       (o_coin),
    .o_credit     (o_credit),
    .o_refund_10  (o_refund_10),
    .o_refund_5   (o_refund_5),
    .o_reject     (o_reject),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert_coin(input logic c5, input logic c10);
    coin_5 = c5;
    coin_10 = c10;
    tick();
    coin_5 = 1'b0;
    coin_10 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {coin_5, coin_10, mode_1, mode_2, mode_3, cancel, coinreturn, done} = '0;
    #12;
    checks++; if (o_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", o_state, S_IDLE); end
    checks++; if (o_credit !== 7'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", o_credit); end
    checks++; if ({o_coin, o_refund_10, o_refund_5, o_reject, o_busy} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {o_coin, o_refund_10, o_refund_5, o_reject, o_busy}); end
    rst_n = 1'b1;
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++; if (o_state !== S_IDLE || o_busy !== 1'b0) begin errors++; $display("FAIL idle_cancel: got state %0d busy %b expected state 0 busy 0", o_state, o_busy); end
  endtask

  task automatic test_exact_payment();
    mode_2 = 1'b1;
    insert_coin(1'b0, 1'b1);
    insert_coin(1'b0, 1'b1);
    checks++; if (o_credit !== 7'd20 || o_state !== S_COLLECT) begin errors++; $display("FAIL exact_credit: got %0d/%0d expected 20/%0d", o_credit, o_state, S_COLLECT); end
    checks++; if (o_coin !== 1'b0) begin errors++; $display("FAIL exact_coin_early: got %b expected 0", o_coin); end
    tick();
    checks++; if (o_state !== S_VEND || o_coin !== 1'b1) begin errors++; $display("FAIL exact_vend: got state %0d coin %b expected state %0d coin 1", o_state, o_coin, S_VEND); end
    tick();
    checks++; if (o_state !== S_PAID || o_coin !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL exact_paid: got state %0d coin %b busy %b expected state %0d coin 0 busy 1", o_state, o_coin, o_busy, S_PAID); end
    checks++; if (o_credit !== 7'd0 || o_refund_10 !== 1'b0 || o_refund_5 !== 1'b0) begin errors++; $display("FAIL exact_no_refund: got credit %0d r10 %b r5 %b expected 0 0 0", o_credit, o_refund_10, o_refund_5); end
    done = 1'b1;
    tick();
    done = 1'b0;
    mode_2 = 1'b0;
    checks++; if (o_state !== S_IDLE || o_credit !== 7'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL exact_done: got state %0d credit %0d busy %b expected 0 0 0", o_state, o_credit, o_busy); end
  endtask

  task automatic test_change();
    mode_2 = 1'b1;
    insert_coin(1'b0, 1'b1);
    insert_coin(1'b1, 1'b0);
    insert_coin(1'b0, 1'b1);
    checks++; if (o_credit !== 7'd25) begin errors++; $display("FAIL change_credit: got %0d expected 25", o_credit); end
    tick();
    checks++; if (o_coin !== 1'b1) begin errors++; $display("FAIL change_vend: got %b expected 1", o_coin); end
    tick();
    checks++; if (o_state !== S_CHANGE || o_credit !== 7'd5 || o_refund_5 !== 1'b1 || o_refund_10 !== 1'b0 || o_coin !== 1'b0) begin errors++; $display("FAIL change_dispense: got state %0d credit %0d r5 %b r10 %b coin %b expected %0d 5 1 0 0", o_state, o_credit, o_refund_5, o_refund_10, o_coin, S_CHANGE); end
    tick();
    checks++; if (o_state !== S_PAID || o_credit !== 7'd0 || o_refund_5 !== 1'b0) begin errors++; $display("FAIL change_paid: got state %0d credit %0d r5 %b expected %0d 0 0", o_state, o_credit, o_refund_5, S_PAID); end
    done = 1'b1;
    tick();
    done = 1'b0;
    mode_2 = 1'b0;
  endtask

  task automatic test_cancel();
    int coin_seen;
    coin_seen = 0;
    mode_3 = 1'b1;
    insert_coin(1'b0, 1'b1);
    insert_coin(1'b0, 1'b1);
    insert_coin(1'b1, 1'b0);
    if (o_coin !== 1'b0) coin_seen++;
    cancel = 1'b1;
    coin_5 = 1'b1;
    tick();
    cancel = 1'b0;
    coin_5 = 1'b0;
    checks++; if (o_state !== S_REFUND || o_credit !== 7'd25 || o_refund_10 !== 1'b1) begin errors++; $display("FAIL cancel_first: got state %0d credit %0d r10 %b expected %0d 25 1", o_state, o_credit, o_refund_10, S_REFUND); end
    checks++; if (o_reject !== 1'b1) begin errors++; $display("FAIL cancel_reject: got %b expected 1", o_reject); end
    if (o_coin !== 1'b0) coin_seen++;
    tick();
    checks++; if (o_credit !== 7'd15 || o_refund_10 !== 1'b1 || o_refund_5 !== 1'b0 || o_reject !== 1'b0) begin errors++; $display("FAIL cancel_second: got credit %0d r10 %b r5 %b rej %b expected 15 1 0 0", o_credit, o_refund_10, o_refund_5, o_reject); end
    if (o_coin !== 1'b0) coin_seen++;
    tick();
    checks++; if (o_credit !== 7'd5 || o_refund_10 !== 1'b0 || o_refund_5 !== 1'b1) begin errors++; $display("FAIL cancel_third: got credit %0d r10 %b r5 %b expected 5 0 1", o_credit, o_refund_10, o_refund_5); end
    if (o_coin !== 1'b0) coin_seen++;
    tick();
    checks++; if (o_state !== S_IDLE || o_credit !== 7'd0 || o_refund_5 !== 1'b0) begin errors++; $display("FAIL cancel_idle: got state %0d credit %0d r5 %b expected 0 0 0", o_state, o_credit, o_refund_5); end
    checks++; if (coin_seen !== 0) begin errors++; $display("FAIL cancel_no_coin: got %0d coin cycles expected 0", coin_seen); end
    mode_3 = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    mode_3 = 1'b1;
    insert_coin(1'b0, 1'b1);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (o_state !== S_COLLECT) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d non-collect cycles expected 0", early); end
    tick();
    checks++; if (o_state !== S_REFUND || o_refund_10 !== 1'b1 || o_credit !== 7'd10) begin errors++; $display("FAIL timeout_refund: got state %0d r10 %b credit %0d expected %0d 1 10", o_state, o_refund_10, o_credit, S_REFUND); end
    tick();
    checks++; if (o_state !== S_IDLE || o_credit !== 7'd0 || o_refund_10 !== 1'b0) begin errors++; $display("FAIL timeout_idle: got state %0d credit %0d r10 %b expected 0 0 0", o_state, o_credit, o_refund_10); end
    mode_3 = 1'b0;
  endtask

  task automatic test_coinreturn();
    mode_1 = 1'b1;
    insert_coin(1'b0, 1'b1);
    tick();
    checks++; if (o_coin !== 1'b1) begin errors++; $display("FAIL cret_vend: got %b expected 1", o_coin); end
    tick();
    checks++; if (o_state !== S_PAID) begin errors++; $display("FAIL cret_paid: got %0d expected %0d", o_state, S_PAID); end
    insert_coin(1'b1, 1'b0);
    checks++; if (o_reject !== 1'b1 || o_credit !== 7'd0 || o_state !== S_PAID) begin errors++; $display("FAIL cret_reject: got rej %b credit %0d state %0d expected 1 0 %0d", o_reject, o_credit, o_state, S_PAID); end
    tick();
    checks++; if (o_reject !== 1'b0) begin errors++; $display("FAIL cret_reject_pulse: got %b expected 0", o_reject); end
    coinreturn = 1'b1;
    tick();
    coinreturn = 1'b0;
    checks++; if (o_state !== S_REFUND || o_credit !== 7'd10 || o_refund_10 !== 1'b1) begin errors++; $display("FAIL cret_refund: got state %0d credit %0d r10 %b expected %0d 10 1", o_state, o_credit, o_refund_10, S_REFUND); end
    tick();
    checks++; if (o_state !== S_IDLE || o_credit !== 7'd0 || o_refund_10 !== 1'b0) begin errors++; $display("FAIL cret_idle: got state %0d credit %0d r10 %b expected 0 0 0", o_state, o_credit, o_refund_10); end
    mode_1 = 1'b0;
  endtask

  task automatic test_saturation_reset();
    insert_coin(1'b1, 1'b1);
    checks++; if (o_credit !== 7'd15 || o_state !== S_COLLECT) begin errors++; $display("FAIL sat_dual_coin: got credit %0d state %0d expected 15 %0d", o_credit, o_state, S_COLLECT); end
    for (int k = 0; k < 10; k++) insert_coin(1'b0, 1'b1);
    insert_coin(1'b1, 1'b0);
    checks++; if (o_credit !== 7'd120 || o_reject !== 1'b0) begin errors++; $display("FAIL sat_fill: got credit %0d rej %b expected 120 0", o_credit, o_reject); end
    insert_coin(1'b0, 1'b1);
    checks++; if (o_credit !== 7'd120 || o_reject !== 1'b1) begin errors++; $display("FAIL sat_reject: got credit %0d rej %b expected 120 1", o_credit, o_reject); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (o_credit !== 7'd0 || o_state !== S_IDLE) begin errors++; $display("FAIL async_reset_state: got credit %0d state %0d expected 0 0", o_credit, o_state); end
    checks++; if ({o_coin, o_refund_10, o_refund_5, o_reject, o_busy} !== 5'b0) begin errors++; $display("FAIL async_reset_outputs: got %b expected 00000", {o_coin, o_refund_10, o_refund_5, o_reject, o_busy}); end
    #3;
    rst_n = 1'b1;
    tick();
    checks++; if (o_state !== S_IDLE || o_refund_10 !== 1'b0 || o_refund_5 !== 1'b0) begin errors++; $display("FAIL post_reset_no_refund: got state %0d r10 %b r5 %b expected 0 0 0", o_state, o_refund_10, o_refund_5); end
  endtask

  initial begin
    test_reset();
    test_exact_payment();
    test_change();
    test_cancel();
    test_timeout();
    test_coinreturn();
    test_saturation_reset();
    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
